// File: rtl/uart_rx_if.sv
// Signal bundle between the 8N1 serial receiver and its user: baud select and
// serial line in, received byte and status strobes out, plus the FSM state for observation.
interface uart_rx_if;
    logic [2:0] baud_rate_select;
    logic       Rx_Serial;
    logic [7:0] Rx_Byte;
    logic       Rx_Done;
    logic       Rx_Active;
    logic       Framing_Error;
    logic [2:0] fsm_state;

    modport master (
        output baud_rate_select, Rx_Serial,
        input  Rx_Byte, Rx_Done, Rx_Active, Framing_Error, fsm_state
    );

    modport slave (
        input  baud_rate_select, Rx_Serial,
        output Rx_Byte, Rx_Done, Rx_Active, Framing_Error, fsm_state
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling at a latched baud divisor,
// one-cycle done / framing-error strobes and break recovery.
module uart_rx (
    input  logic      clock,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        RX_CLEANUP   = 3'd4,
        RX_RECOVER   = 3'd5
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [10:0] clk_count;
    logic [10:0] bit_max;
    logic [10:0] half;
    logic [2:0]  bit_index;
    logic [7:0]  shift;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic        rx_active;
    logic        framing_error;

    // Returns N-1 (the last clk_count value of a bit period) for each select code.
    function automatic logic [10:0] decode_max(input logic [2:0] sel);
        case (sel)
            3'b000:  return 11'd1041;
            3'b001:  return 11'd694;
            3'b010:  return 11'd520;
            3'b011:  return 11'd260;
            3'b100:  return 11'd173;
            3'b101:  return 11'd86;
            3'b110:  return 11'd78;
            default: return 11'd38;
        endcase
    endfunction

    assign half = bit_max >> 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            clk_count     <= 11'd0;
            bit_max       <= 11'd1041;
            bit_index     <= 3'd0;
            shift         <= 8'd0;
            rx_byte       <= 8'd0;
            rx_done       <= 1'b0;
            rx_active     <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    rx_active <= 1'b0;
                    clk_count <= 11'd0;
                    bit_index <= 3'd0;
                    if (!rx_s) begin
                        bit_max   <= decode_max(bus.baud_rate_select);
                        rx_active <= 1'b1;
                        state     <= RX_START_BIT;
                    end
                end
                RX_START_BIT: begin
                    if (clk_count == half) begin
                        clk_count <= 11'd0;
                        if (!rx_s) begin
                            state <= RX_DATA_BITS;
                        end else begin
                            // Line went high before mid start bit: a glitch, not a frame.
                            rx_active <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        clk_count <= clk_count + 11'd1;
                    end
                end
                RX_DATA_BITS: begin
                    if (clk_count == bit_max) begin
                        clk_count        <= 11'd0;
                        shift[bit_index] <= rx_s;
                        if (bit_index == 3'd7) begin
                            bit_index <= 3'd0;
                            state     <= RX_STOP_BIT;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 11'd1;
                    end
                end
                RX_STOP_BIT: begin
                    if (clk_count == bit_max) begin
                        clk_count <= 11'd0;
                        rx_active <= 1'b0;
                        if (rx_s) begin
                            rx_byte <= shift;
                            rx_done <= 1'b1;
                            state   <= RX_CLEANUP;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= RX_RECOVER;
                        end
                    end else begin
                        clk_count <= clk_count + 11'd1;
                    end
                end
                RX_CLEANUP: begin
                    rx_active <= 1'b0;
                    state     <= IDLE;
                end
                RX_RECOVER: begin
                    // Wait out a break so a held-low line yields a single error.
                    rx_active <= 1'b0;
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    rx_active <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.Rx_Byte       = rx_byte;
    assign bus.Rx_Done       = rx_done;
    assign bus.Rx_Active     = rx_active;
    assign bus.Framing_Error = framing_error;
    assign bus.fsm_state     = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven bit by bit at the selected divisor, expected
// bytes are queued at drive time and checked when Rx_Done fires.
module tb_uart_rx;
    logic clock;
    logic reset;
    uart_rx_if bus();

    uart_rx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int fe_cnt = 0;
    int last_done_cyc = 0;
    int frame_start_cyc = 0;
    int active_drops = 0;
    bit active_en = 0;
    logic [7:0] exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clock) begin
        logic [7:0] exp_b;
        if (!reset && (bus.Rx_Done || bus.Framing_Error)) begin
            checks++;
            if (bus.Rx_Done && bus.Framing_Error) begin
                failures++;
                $display("FAIL done_and_ferr_together got=1 expected=0 at cyc=%0d", cyc);
            end
        end
        if (bus.Rx_Done) begin
            done_cnt++;
            last_done_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got=%02h expected=none at cyc=%0d", bus.Rx_Byte, cyc);
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.Rx_Byte !== exp_b) begin
                    failures++;
                    $display("FAIL rx_byte got=%02h expected=%02h at cyc=%0d", bus.Rx_Byte, exp_b, cyc);
                end
            end
        end
        if (bus.Framing_Error) fe_cnt++;
        if (active_en && bus.Rx_Active !== 1'b1) active_drops++;
    end

    task automatic idle(input int n);
        bus.Rx_Serial = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input int n, input logic stop, input bit push);
        @(negedge clock);
        if (push) exp_q.push_back(b);
        bus.Rx_Serial = 1'b0;
        frame_start_cyc = cyc;
        repeat (n) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.Rx_Serial = b[i];
            repeat (n) @(negedge clock);
        end
        bus.Rx_Serial = stop;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.Rx_Serial = 1'b1;
        bus.baud_rate_select = 3'b111;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.Rx_Byte, bus.Rx_Done, bus.Rx_Active, bus.Framing_Error} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%02h/%b/%b/%b expected=00/0/0/0",
                     bus.Rx_Byte, bus.Rx_Done, bus.Rx_Active, bus.Framing_Error);
        end
        reset = 1'b0;
        idle(5);
        checks++;
        if (bus.fsm_state !== 3'd0 || bus.Rx_Active !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got state=%0d active=%b expected state=0 active=0",
                     bus.fsm_state, bus.Rx_Active);
        end
    endtask

    task automatic test_single_byte;
        int d0, f0, lat;
        d0 = done_cnt; f0 = fe_cnt; active_drops = 0;
        bus.baud_rate_select = 3'b111;
        fork
            send_frame(8'hA5, 39, 1'b1, 1'b1);
            begin
                repeat (6) @(negedge clock);
                active_en = 1'b1;
                repeat (9 * 39) @(negedge clock);
                active_en = 1'b0;
            end
        join
        idle(5);
        lat = last_done_cyc - frame_start_cyc;
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL single_done_count got=%0d expected=1", done_cnt - d0);
        end
        checks++;
        if (lat < 372 || lat > 374) begin
            failures++;
            $display("FAIL single_latency got=%0d expected=373+-1", lat);
        end
        checks++;
        if (fe_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL single_ferr got=%0d expected=0", fe_cnt - f0);
        end
        checks++;
        if (active_drops !== 0) begin
            failures++;
            $display("FAIL single_active_drops got=%0d expected=0", active_drops);
        end
        checks++;
        if (bus.Rx_Active !== 1'b0 || bus.Rx_Byte !== 8'hA5) begin
            failures++;
            $display("FAIL single_after got active=%b byte=%02h expected active=0 byte=a5",
                     bus.Rx_Active, bus.Rx_Byte);
        end
    endtask

    task automatic test_back_to_back;
        int d0, f0;
        logic [7:0] vals[3];
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C;
        d0 = done_cnt; f0 = fe_cnt;
        bus.baud_rate_select = 3'b101;
        idle(2);
        for (int i = 0; i < 3; i++) send_frame(vals[i], 87, 1'b1, 1'b1);
        idle(10);
        checks++;
        if (done_cnt - d0 !== 3 || fe_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL b2b_counts got done=%0d ferr=%0d expected done=3 ferr=0",
                     done_cnt - d0, fe_cnt - f0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL b2b_queue got=%0d pending expected=0", exp_q.size());
        end
    endtask

    task automatic test_glitch;
        int d0, f0;
        d0 = done_cnt; f0 = fe_cnt;
        bus.baud_rate_select = 3'b111;
        @(negedge clock);
        bus.Rx_Serial = 1'b0;
        repeat (10) @(negedge clock);
        bus.Rx_Serial = 1'b1;
        checks++;
        if (bus.Rx_Active !== 1'b1) begin
            failures++;
            $display("FAIL glitch_active got=%b expected=1", bus.Rx_Active);
        end
        idle(40);
        checks++;
        if (done_cnt - d0 !== 0 || fe_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL glitch_flags got done=%0d ferr=%0d expected done=0 ferr=0",
                     done_cnt - d0, fe_cnt - f0);
        end
        checks++;
        if (bus.Rx_Active !== 1'b0 || bus.fsm_state !== 3'd0 || bus.Rx_Byte !== 8'h3C) begin
            failures++;
            $display("FAIL glitch_idle got active=%b state=%0d byte=%02h expected active=0 state=0 byte=3c",
                     bus.Rx_Active, bus.fsm_state, bus.Rx_Byte);
        end
    endtask

    task automatic test_framing_error;
        int d0, f0;
        d0 = done_cnt; f0 = fe_cnt;
        bus.baud_rate_select = 3'b111;
        send_frame(8'h55, 39, 1'b0, 1'b0);
        repeat (500) @(negedge clock);
        checks++;
        if (bus.Rx_Active !== 1'b0) begin
            failures++;
            $display("FAIL break_active got=%b expected=0", bus.Rx_Active);
        end
        idle(80);
        checks++;
        if (fe_cnt - f0 !== 1 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL break_counts got ferr=%0d done=%0d expected ferr=1 done=0",
                     fe_cnt - f0, done_cnt - d0);
        end
        checks++;
        if (bus.Rx_Byte !== 8'h3C) begin
            failures++;
            $display("FAIL break_byte_held got=%02h expected=3c", bus.Rx_Byte);
        end
        send_frame(8'h81, 39, 1'b1, 1'b1);
        idle(5);
        checks++;
        if (done_cnt - d0 !== 1 || bus.Rx_Byte !== 8'h81) begin
            failures++;
            $display("FAIL break_next got done=%0d byte=%02h expected done=1 byte=81",
                     done_cnt - d0, bus.Rx_Byte);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0, f0;
        d0 = done_cnt; f0 = fe_cnt;
        bus.baud_rate_select = 3'b111;
        fork
            send_frame(8'hC3, 39, 1'b1, 1'b0);
            begin
                repeat (5 * 39 + 10) @(negedge clock);
                checks++;
                if (bus.Rx_Active !== 1'b1) begin
                    failures++;
                    $display("FAIL midreset_active_before got=%b expected=1", bus.Rx_Active);
                end
                reset = 1'b1;
                #1;
                checks++;
                if ({bus.Rx_Byte, bus.Rx_Done, bus.Rx_Active, bus.Framing_Error} !== 11'd0) begin
                    failures++;
                    $display("FAIL midreset_async got=%02h/%b/%b/%b expected=00/0/0/0",
                             bus.Rx_Byte, bus.Rx_Done, bus.Rx_Active, bus.Framing_Error);
                end
            end
        join
        idle(10);
        reset = 1'b0;
        idle(10);
        checks++;
        if (done_cnt - d0 !== 0 || fe_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL midreset_flags got done=%0d ferr=%0d expected done=0 ferr=0",
                     done_cnt - d0, fe_cnt - f0);
        end
        send_frame(8'h12, 39, 1'b1, 1'b1);
        idle(5);
        checks++;
        if (done_cnt - d0 !== 1 || bus.Rx_Byte !== 8'h12) begin
            failures++;
            $display("FAIL midreset_next got done=%0d byte=%02h expected done=1 byte=12",
                     done_cnt - d0, bus.Rx_Byte);
        end
    endtask

    task automatic test_baud_change;
        int d0, f0;
        d0 = done_cnt; f0 = fe_cnt;
        bus.baud_rate_select = 3'b110;
        fork
            send_frame(8'h96, 79, 1'b1, 1'b1);
            begin
                repeat (3 * 79 + $urandom_range(5, 60)) @(negedge clock);
                bus.baud_rate_select = 3'b000;
            end
        join
        idle(5);
        checks++;
        if (done_cnt - d0 !== 1 || bus.Rx_Byte !== 8'h96) begin
            failures++;
            $display("FAIL baud_change got done=%0d byte=%02h expected done=1 byte=96",
                     done_cnt - d0, bus.Rx_Byte);
        end
        idle(20);
        send_frame(8'h69, 1042, 1'b1, 1'b1);
        idle(5);
        checks++;
        if (done_cnt - d0 !== 2 || fe_cnt - f0 !== 0 || bus.Rx_Byte !== 8'h69) begin
            failures++;
            $display("FAIL baud_slow got done=%0d ferr=%0d byte=%02h expected done=2 ferr=0 byte=69",
                     done_cnt - d0, fe_cnt - f0, bus.Rx_Byte);
        end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_glitch;
        test_framing_error;
        test_reset_mid_frame;
        test_baud_change;
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL final_queue got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit).
- Companion to the UART transmitter in the same UART subsystem, and uses the same 3-bit baud select encoding.
- Oversamples the line with the system clock and samples each bit at its mid-point.
- Presents each received byte with a one-cycle done strobe and flags frames whose stop bit is bad.

Parameters:
- None. Baud divisors are fixed by the baud_rate_select decode below.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- baud_rate_select  in  3  clocks-per-bit select (N):
  - 000=1042, 001=695, 010=521, 011=261
  - 100=174, 101=87, 110=79, 111=39
- Rx_Serial  in  1  serial line, asynchronous to clock; idles high.
- Rx_Byte  out  8  last correctly framed byte; holds its value until the next good frame.
- Rx_Done  out  1  one-cycle pulse: Rx_Byte was updated this cycle.
- Rx_Active  out  1  high while a frame is being received.
- Framing_Error  out  1  one-cycle pulse: stop bit was sampled low.

Behaviour:
- Reset (asynchronous, active-high):
  - State=IDLE, clk_count=0, bit_index=0, shift register=0.
  - Rx_Byte=0, Rx_Done=0, Rx_Active=0, Framing_Error=0.
  - Both synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately, with no Rx_Done or Framing_Error.
- Synchronizer:
  - Rx_Serial passes through 2 flops; the FSM uses only the synced value (rx_s).
  - Input-to-FSM latency is 2 clocks.
- Baud latch: N is decoded and registered on the IDLE->RX_START_BIT transition. Changes to baud_rate_select mid-frame have no effect until the next frame.
- clk_count is 11 bits and never exceeds N-1. Define H = (N-1)>>1, i.e. 520, 347, 260, 130, 86, 43, 39, 19.
- States:
  - IDLE:
    - Rx_Active=0, clk_count=0, bit_index=0.
    - If rx_s==0: latch N, set Rx_Active=1, go to RX_START_BIT.
  - RX_START_BIT:
    - Count clk_count 0..H.
    - At clk_count==H: if rx_s==0, clear clk_count and go to RX_DATA_BITS.
    - If rx_s==1 at that point, treat it as a glitch: return to IDLE, Rx_Active=0, no flags.
  - RX_DATA_BITS:
    - Count clk_count 0..N-1.
    - At N-1: shift[bit_index] <= rx_s and clear clk_count.
    - If bit_index==7, go to RX_STOP_BIT with bit_index=0; otherwise increment bit_index.
  - RX_STOP_BIT:
    - Count 0..N-1; at N-1 sample rx_s.
    - Sample 1: Rx_Byte <= shift, Rx_Done=1 for exactly that one cycle, go to RX_CLEANUP.
    - Sample 0: Framing_Error=1 for one cycle, Rx_Byte unchanged, go to RX_RECOVER.
  - RX_CLEANUP: one clock; Rx_Active=0; go to IDLE.
  - RX_RECOVER:
    - Rx_Active=0; stay until rx_s==1, then go to IDLE.
    - A held-low (break) line therefore produces one Framing_Error, not repeated frames.
  - Unused encodings: go to IDLE.
- Timing:
  - Rx_Done rises 3 + H + 9N clocks (±1) after the Rx_Serial falling edge.
  - The earliest next start edge is accepted 2 clocks after Rx_Done, so back-to-back frames with a full-length stop bit are received without loss.
- Rx_Done and Framing_Error are never high in the same cycle. Neither can be high while State==IDLE after reset.

Test Plan:
- Single byte:
  - Stimulus: select=111 (N=39); drive frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) at 39 clocks/bit.
  - Required: Rx_Byte=0xA5, one Rx_Done pulse ~373 clocks after the start edge; Framing_Error=0; Rx_Active high for the whole frame.
- Back-to-back:
  - Stimulus: select=101 (N=87); frames 0x00, 0xFF, 0x3C with no idle gap.
  - Required: three Rx_Done pulses, values 0x00, 0xFF, 0x3C in order.
- Glitch:
  - Stimulus: select=111; 10-clock low pulse on idle line.
  - Required: return to IDLE at sample point H=19; no Rx_Done, no Framing_Error; Rx_Byte unchanged.
- Framing error / break:
  - Stimulus: frame 0x55 with stop bit 0, then line held low 500 clocks, then high.
  - Required: exactly one Framing_Error pulse; Rx_Byte keeps the prior value; the next valid frame 0x81 is received correctly.
- Reset mid-frame:
  - Stimulus: assert reset during data bit 4 of 0xC3.
  - Required: all outputs 0 asynchronously; no Rx_Done; the following frame 0x12 is received correctly.
- Baud change mid-frame:
  - Stimulus: start 0x96 at select=110 (N=79); switch select to 000 during bit 2.
  - Required: the frame decodes as 0x96. The next frame at N=1042 also decodes correctly.
